pae_tlb: RTL and testbench
==========================

Name: pae_tlb

Overview:
- Parametrised, fully associative, ASID-tagged TLB. It is the next generation of the PAE32 VA-to-PA high-bit translator.
- Translates a virtual page number (VPN) to a physical page number (PPN) with one-cycle registered lookup.
- Blocks on a miss and waits for a refill from the OS/walker, then automatically replays the missed request.
- One instance serves the instruction side and one serves the data side.

Parameters:
- VPN_W, 8, virtual page number width
- PPN_W, 16, physical page number width; must be >= VPN_W
- ENTRIES, 8, number of TLB entries; power of two, 2..32
- ASID_W, 8, address-space identifier width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- mmu_enable  in  1  0 = bypass (identity translation)
- supervisor_mode  in  1  1 = privileged access
- asid  in  ASID_W  current address space
- req_valid  in  1  lookup request
- req_ready  out  1  request accepted when req_valid && req_ready
- req_vpn  in  VPN_W  virtual page number
- rsp_valid  out  1  one-cycle response strobe
- rsp_ppn  out  PPN_W  translated page number
- rsp_miss  out  1  no matching entry (with rsp_valid)
- rsp_fault  out  1  user access to supervisor-only page (with rsp_valid)
- fill_valid  in  1  refill write request
- fill_ready  out  1  refill accepted when fill_valid && fill_ready
- fill_vpn  in  VPN_W  refill tag
- fill_ppn  in  PPN_W  refill data
- fill_asid  in  ASID_W  refill ASID
- fill_user  in  1  page accessible in user mode
- fill_global  in  1  entry matches any ASID
- flush_all  in  1  invalidate every entry
- flush_asid  in  1  invalidate non-global entries whose ASID equals asid

Behaviour:
- Reset (rst=0, async):
  - all valid bits 0, victim pointer 0, state RUN
  - rsp_valid/rsp_miss/rsp_fault 0, rsp_ppn 0
  - req_ready 1 once rst deasserts
- Entry match: valid && tag==vpn && (global || entry_asid==asid).
- Lookup timing: request accepted at edge N produces rsp_valid=1 for exactly one cycle after edge N+1.
  - hit, allowed: rsp_ppn=entry ppn, miss=0, fault=0
  - hit, !supervisor_mode && !user: fault=1, rsp_ppn=0
  - no match: miss=1, rsp_ppn=0; enter MISS_WAIT
- Bypass: mmu_enable=0 gives rsp_ppn = zero-extended req_vpn, miss=0, fault=0, same one-cycle latency. The TLB array is untouched.
- States:
  - RUN: req_ready = !fill_valid && !flush_all && !flush_asid. fill_ready=1 (preload allowed).
  - MISS_WAIT: req_ready=0, fill_ready=1; missed VPN/ASID/privilege held internally.
    - accepted fill -> write entry -> REPLAY
    - flush -> RUN, no replay, no response
  - REPLAY: req_ready=0, fill_ready=0. Re-lookup the held request one cycle after the write; rsp_valid asserts the following cycle.
    - hit -> RUN
    - miss (fill tag differed) -> rsp_miss pulse, back to MISS_WAIT
- Fill slot selection:
  - an existing matching entry (same vpn, same asid or either global) is overwritten; no duplicates
  - else the lowest-index invalid entry
  - else the entry at the victim pointer; pointer then increments modulo ENTRIES
  - the pointer advances only on pointer-selected fills
- Flush rules:
  - flush_all/flush_asid take effect at the next edge
  - flush has priority over a same-cycle fill; fill_ready=0 while either flush is high
  - a flush does not reset the victim pointer
- A lookup in the same cycle as a write is impossible (req_ready gating), so the array never reads stale data.
- mmu_enable/supervisor_mode/asid are sampled at request acceptance; replay uses the held copies.
- rst asserted mid-MISS_WAIT or mid-REPLAY returns to reset state; no response is emitted.

Test Plan:
- Reset, then fill vpn=0x12 ppn=0xABCD asid=3 user=1; lookup 0x12 with asid=3 -> next cycle rsp_valid=1, rsp_ppn=0xABCD, miss=0.
- Lookup vpn=0x40 with empty TLB -> rsp_miss=1, req_ready=0. Fill 0x40->0x0100 -> replay response rsp_ppn=0x0100, then req_ready=1.
- ENTRIES=8: fill 9 distinct VPNs -> the 9th evicts entry 0; lookup of the first VPN misses, VPNs 2..9 hit.
- Entry user=0, supervisor_mode=0 lookup -> rsp_fault=1, rsp_ppn=0. Same lookup with supervisor_mode=1 -> hit, fault=0.
- Global entry and asid=5 entry loaded; flush_asid with asid=5 -> asid-5 entry misses, global entry still hits under asid=7. mmu_enable=0 lookup 0x3C -> rsp_ppn=0x003C.
- In MISS_WAIT, assert flush_all together with fill_valid -> fill dropped, state RUN, no rsp_valid; rst pulse during REPLAY -> no response, all entries invalid.

Source files
------------

// File: rtl/pae_tlb.sv
// pae_tlb: fully associative, ASID-tagged VPN->PPN translation buffer.
// A request is captured at acceptance, looked up against the entry array in
// the following cycle, and answered with a one-cycle registered response.
// A miss parks the held request until a refill arrives, then replays it.
module pae_tlb #(
  parameter int VPN_W   = 8,
  parameter int PPN_W   = 16,
  parameter int ENTRIES = 8,
  parameter int ASID_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mmu_enable,
  input  logic              supervisor_mode,
  input  logic [ASID_W-1:0] asid,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [VPN_W-1:0]  req_vpn,
  output logic              rsp_valid,
  output logic [PPN_W-1:0]  rsp_ppn,
  output logic              rsp_miss,
  output logic              rsp_fault,
  input  logic              fill_valid,
  output logic              fill_ready,
  input  logic [VPN_W-1:0]  fill_vpn,
  input  logic [PPN_W-1:0]  fill_ppn,
  input  logic [ASID_W-1:0] fill_asid,
  input  logic              fill_user,
  input  logic              fill_global,
  input  logic              flush_all,
  input  logic              flush_asid
);

  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic [1:0] {RUN, MISS_WAIT, REPLAY} state_e;

  state_e state_q;

  // Entry array
  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] global_q;
  logic [ENTRIES-1:0] user_q;
  logic [VPN_W-1:0]   tag_q     [ENTRIES];
  logic [PPN_W-1:0]   ppn_q     [ENTRIES];
  logic [ASID_W-1:0]  asidTab_q [ENTRIES];
  logic [IDX_W-1:0]   victim_q;

  // Captured request; doubles as the held copy while a miss is outstanding
  logic              lkValid_q;
  logic [VPN_W-1:0]  lkVpn_q;
  logic [ASID_W-1:0] lkAsid_q;
  logic              lkSup_q;
  logic              lkEn_q;

  // Registered response
  logic              rspValid_q;
  logic [PPN_W-1:0]  rspPpn_q;
  logic              rspMiss_q;
  logic              rspFault_q;

  logic              hit;
  logic [PPN_W-1:0]  hitPpn;
  logic              hitUser;
  logic              missPend;
  logic              anyFlush;
  logic              fillFire;
  logic [IDX_W-1:0]  fillSlot;
  logic              useVictim;
  logic [PPN_W-1:0]  rspPpn_d;
  logic              rspMiss_d;
  logic              rspFault_d;

  // Associative match of the captured request against every valid entry
  always_comb begin
    hit     = 1'b0;
    hitPpn  = '0;
    hitUser = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!hit && valid_q[i] && (tag_q[i] == lkVpn_q) &&
          (global_q[i] || (asidTab_q[i] == lkAsid_q))) begin
        hit     = 1'b1;
        hitPpn  = ppn_q[i];
        hitUser = user_q[i];
      end
    end
  end

  // A lookup in flight that is about to miss stalls new requests and fills,
  // so nothing slips past the transition into MISS_WAIT
  assign missPend   = lkValid_q && lkEn_q && !hit && (state_q == RUN);
  assign anyFlush   = flush_all || flush_asid;
  assign req_ready  = (state_q == RUN) && !fill_valid && !anyFlush && !missPend;
  assign fill_ready = (state_q != REPLAY) && !anyFlush && !missPend;
  assign fillFire   = fill_valid && fill_ready;

  // Refill slot: existing match first, then lowest invalid, then victim pointer
  always_comb begin
    logic foundMatch;
    logic foundFree;
    foundMatch = 1'b0;
    foundFree  = 1'b0;
    fillSlot   = victim_q;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!foundMatch && valid_q[i] && (tag_q[i] == fill_vpn) &&
          (global_q[i] || fill_global || (asidTab_q[i] == fill_asid))) begin
        foundMatch = 1'b1;
        fillSlot   = IDX_W'(i);
      end
    end
    if (!foundMatch) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (!foundFree && !valid_q[i]) begin
          foundFree = 1'b1;
          fillSlot  = IDX_W'(i);
        end
      end
    end
    useVictim = !foundMatch && !foundFree;
  end

  // Response value for the lookup being resolved this cycle
  always_comb begin
    rspPpn_d   = '0;
    rspMiss_d  = 1'b0;
    rspFault_d = 1'b0;
    if (!lkEn_q) begin
      rspPpn_d = PPN_W'(lkVpn_q);
    end else if (!hit) begin
      rspMiss_d = 1'b1;
    end else if (!lkSup_q && !hitUser) begin
      rspFault_d = 1'b1;
    end else begin
      rspPpn_d = hitPpn;
    end
  end

  // Entry array maintenance: flushes win over fills, pointer moves only on evictions
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= '0;
      global_q <= '0;
      user_q   <= '0;
      victim_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]     <= '0;
        ppn_q[i]     <= '0;
        asidTab_q[i] <= '0;
      end
    end else if (flush_all) begin
      valid_q <= '0;
    end else if (flush_asid) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (!global_q[i] && (asidTab_q[i] == asid)) begin
          valid_q[i] <= 1'b0;
        end
      end
    end else if (fillFire) begin
      valid_q[fillSlot]   <= 1'b1;
      global_q[fillSlot]  <= fill_global;
      user_q[fillSlot]    <= fill_user;
      tag_q[fillSlot]     <= fill_vpn;
      ppn_q[fillSlot]     <= fill_ppn;
      asidTab_q[fillSlot] <= fill_asid;
      if (useVictim) begin
        victim_q <= victim_q + 1'b1;
      end
    end
  end

  // Control FSM with request capture and registered response strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      lkValid_q  <= 1'b0;
      lkVpn_q    <= '0;
      lkAsid_q   <= '0;
      lkSup_q    <= 1'b0;
      lkEn_q     <= 1'b0;
      rspValid_q <= 1'b0;
      rspPpn_q   <= '0;
      rspMiss_q  <= 1'b0;
      rspFault_q <= 1'b0;
    end else begin
      lkValid_q  <= req_valid && req_ready;
      rspValid_q <= 1'b0;
      rspPpn_q   <= '0;
      rspMiss_q  <= 1'b0;
      rspFault_q <= 1'b0;
      if (req_valid && req_ready) begin
        lkVpn_q  <= req_vpn;
        lkAsid_q <= asid;
        lkSup_q  <= supervisor_mode;
        lkEn_q   <= mmu_enable;
      end
      case (state_q)
        RUN: begin
          if (lkValid_q) begin
            rspValid_q <= 1'b1;
            rspPpn_q   <= rspPpn_d;
            rspMiss_q  <= rspMiss_d;
            rspFault_q <= rspFault_d;
            if (rspMiss_d) begin
              state_q <= MISS_WAIT;
            end
          end
        end
        MISS_WAIT: begin
          if (anyFlush) begin
            state_q <= RUN;
          end else if (fillFire) begin
            state_q <= REPLAY;
          end
        end
        REPLAY: begin
          rspValid_q <= 1'b1;
          rspPpn_q   <= rspPpn_d;
          rspMiss_q  <= rspMiss_d;
          rspFault_q <= rspFault_d;
          state_q    <= rspMiss_d ? MISS_WAIT : RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign rsp_valid = rspValid_q;
  assign rsp_ppn   = rspPpn_q;
  assign rsp_miss  = rspMiss_q;
  assign rsp_fault = rspFault_q;

endmodule

// File: tb/tb_pae_tlb.sv
// tb_pae_tlb: table-driven lookups plus hand-written miss/flush/reset sequences.
// Expected responses are queued when a request or replaying fill is accepted
// and compared (value and latency) when the DUT strobes rsp_valid.
module tb_pae_tlb;

  logic        clk = 1'b0;
  logic        rst;
  logic        mmu_enable;
  logic        supervisor_mode;
  logic [7:0]  asid;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_vpn;
  logic        rsp_valid;
  logic [15:0] rsp_ppn;
  logic        rsp_miss;
  logic        rsp_fault;
  logic        fill_valid;
  logic        fill_ready;
  logic [7:0]  fill_vpn;
  logic [15:0] fill_ppn;
  logic [7:0]  fill_asid;
  logic        fill_user;
  logic        fill_global;
  logic        flush_all;
  logic        flush_asid;

  typedef struct {
    logic [7:0]  vpn;
    logic [7:0]  asid;
    logic        sup;
    logic        en;
    logic [15:0] ppn;
    logic        miss;
    logic        fault;
  } vec_t;

  typedef struct {
    logic [15:0] ppn;
    logic        miss;
    logic        fault;
    int          due;
  } exp_t;

  exp_t expQ[$];
  exp_t expHead;
  vec_t tbl[12];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  pae_tlb dut (
    .clk(clk), .rst(rst), .mmu_enable(mmu_enable), .supervisor_mode(supervisor_mode),
    .asid(asid), .req_valid(req_valid), .req_ready(req_ready), .req_vpn(req_vpn),
    .rsp_valid(rsp_valid), .rsp_ppn(rsp_ppn), .rsp_miss(rsp_miss), .rsp_fault(rsp_fault),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_vpn(fill_vpn),
    .fill_ppn(fill_ppn), .fill_asid(fill_asid), .fill_user(fill_user),
    .fill_global(fill_global), .flush_all(flush_all), .flush_asid(flush_asid)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter used for latency checks
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mkVec(input logic [7:0] vpn, input logic [7:0] a, input logic sup,
                                 input logic en, input logic [15:0] ppn, input logic miss,
                                 input logic fault);
    vec_t v;
    v.vpn = vpn; v.asid = a; v.sup = sup; v.en = en;
    v.ppn = ppn; v.miss = miss; v.fault = fault;
    return v;
  endfunction

  task automatic pushExp(input logic [15:0] ppn, input logic miss, input logic fault);
    exp_t e;
    e.ppn = ppn; e.miss = miss; e.fault = fault; e.due = cyc + 2;
    expQ.push_back(e);
  endtask

  // Drive one lookup, wait (bounded) for acceptance and queue its expectation
  task automatic applyStimulus(input vec_t v);
    int  tries = 0;
    logic ok = 1'b0;
    req_valid = 1'b1; req_vpn = v.vpn; asid = v.asid;
    supervisor_mode = v.sup; mmu_enable = v.en;
    while (!ok && tries < 50) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        pushExp(v.ppn, v.miss, v.fault);
      end
      @(posedge clk); #1;
      tries++;
    end
    req_valid = 1'b0;
    if (!ok) checkOutput("req_ready timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic doFill(input logic [7:0] vpn, input logic [15:0] ppn, input logic [7:0] a,
                        input logic user, input logic glob, input logic replay);
    int  tries = 0;
    logic ok = 1'b0;
    fill_valid = 1'b1; fill_vpn = vpn; fill_ppn = ppn; fill_asid = a;
    fill_user = user; fill_global = glob;
    while (!ok && tries < 50) begin
      @(negedge clk);
      if (fill_ready) begin
        ok = 1'b1;
        if (replay) pushExp(ppn, 1'b0, 1'b0);
      end
      @(posedge clk); #1;
      tries++;
    end
    fill_valid = 1'b0;
    if (!ok) checkOutput("fill_ready timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic doFlush(input logic all, input logic [7:0] a);
    flush_all = all; flush_asid = !all; asid = a;
    @(posedge clk); #1;
    flush_all = 1'b0; flush_asid = 1'b0;
  endtask

  // Leave MISS_WAIT with a flush that matches no entry
  task automatic escapeMiss();
    @(posedge clk); #1;
    doFlush(1'b0, 8'hFF);
  endtask

  // Scoreboard: every response strobe must match the oldest expectation
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected rsp_valid", {31'd0, rsp_valid}, 32'd0);
      end else begin
        expHead = expQ.pop_front();
        checkOutput("rsp_ppn", {16'd0, rsp_ppn}, {16'd0, expHead.ppn});
        checkOutput("rsp_miss", {31'd0, rsp_miss}, {31'd0, expHead.miss});
        checkOutput("rsp_fault", {31'd0, rsp_fault}, {31'd0, expHead.fault});
        checkOutput("rsp latency", cyc, expHead.due);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Eviction table: first VPN evicted by the 9th fill, the rest survive
    tbl[0] = mkVec(8'h80, 8'd3, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++)
      tbl[i] = mkVec(8'h80 + 8'(i), 8'd3, 1'b0, 1'b1, 16'h1080 + 16'(i), 1'b0, 1'b0);
    tbl[9]  = mkVec(8'h82, 8'd4, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    tbl[10] = mkVec(8'h3C, 8'd4, 1'b0, 1'b0, 16'h003C, 1'b0, 1'b0);
    tbl[11] = mkVec(8'hFF, 8'd3, 1'b1, 1'b0, 16'h00FF, 1'b0, 1'b0);

    rst = 1'b0; mmu_enable = 1'b1; supervisor_mode = 1'b0; asid = '0;
    req_valid = 1'b0; req_vpn = '0; fill_valid = 1'b0; fill_vpn = '0; fill_ppn = '0;
    fill_asid = '0; fill_user = 1'b0; fill_global = 1'b0; flush_all = 1'b0; flush_asid = 1'b0;

    // Reset state
    @(negedge clk);
    checkOutput("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("reset rsp_ppn", {16'd0, rsp_ppn}, 32'd0);
    checkOutput("reset rsp_miss", {31'd0, rsp_miss}, 32'd0);
    checkOutput("reset rsp_fault", {31'd0, rsp_fault}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("req_ready after reset", {31'd0, req_ready}, 32'd1);
    checkOutput("fill_ready after reset", {31'd0, fill_ready}, 32'd1);
    @(posedge clk); #1;

    // Preload and hit
    doFill(8'h12, 16'hABCD, 8'd3, 1'b1, 1'b0, 1'b0);
    applyStimulus(mkVec(8'h12, 8'd3, 1'b0, 1'b1, 16'hABCD, 1'b0, 1'b0));

    // Miss, refill, replay
    applyStimulus(mkVec(8'h40, 8'd3, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0));
    @(posedge clk); #1;
    checkOutput("req_ready in miss wait", {31'd0, req_ready}, 32'd0);
    doFill(8'h40, 16'h0100, 8'd3, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    checkOutput("req_ready after replay", {31'd0, req_ready}, 32'd1);

    // Capacity eviction through the victim pointer
    doFlush(1'b1, 8'd0);
    for (int i = 0; i < 9; i++)
      doFill(8'h80 + 8'(i), 16'h1080 + 16'(i), 8'd3, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i]);
      if (tbl[i].miss) escapeMiss();
    end

    // Pointer advances once per eviction, not on in-place overwrite
    doFill(8'h89, 16'h1089, 8'd3, 1'b1, 1'b0, 1'b0);
    applyStimulus(mkVec(8'h81, 8'd3, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0));
    escapeMiss();
    applyStimulus(mkVec(8'h89, 8'd3, 1'b0, 1'b1, 16'h1089, 1'b0, 1'b0));
    doFill(8'h82, 16'h2222, 8'd3, 1'b1, 1'b0, 1'b0);
    applyStimulus(mkVec(8'h82, 8'd3, 1'b0, 1'b1, 16'h2222, 1'b0, 1'b0));
    doFill(8'h8A, 16'h108A, 8'd3, 1'b1, 1'b0, 1'b0);
    applyStimulus(mkVec(8'h82, 8'd3, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0));
    escapeMiss();
    applyStimulus(mkVec(8'h83, 8'd3, 1'b0, 1'b1, 16'h1083, 1'b0, 1'b0));

    // Supervisor-only page
    doFlush(1'b1, 8'd0);
    doFill(8'h20, 16'h0555, 8'd3, 1'b0, 1'b0, 1'b0);
    applyStimulus(mkVec(8'h20, 8'd3, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1));
    applyStimulus(mkVec(8'h20, 8'd3, 1'b1, 1'b1, 16'h0555, 1'b0, 1'b0));

    // Global entry survives an ASID flush; bypass translation
    doFill(8'h30, 16'h0AAA, 8'd1, 1'b1, 1'b1, 1'b0);
    doFill(8'h31, 16'h0BBB, 8'd5, 1'b1, 1'b0, 1'b0);
    applyStimulus(mkVec(8'h31, 8'd5, 1'b0, 1'b1, 16'h0BBB, 1'b0, 1'b0));
    doFlush(1'b0, 8'd5);
    applyStimulus(mkVec(8'h31, 8'd5, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0));
    escapeMiss();
    applyStimulus(mkVec(8'h30, 8'd7, 1'b0, 1'b1, 16'h0AAA, 1'b0, 1'b0));
    applyStimulus(mkVec(8'h3C, 8'd7, 1'b0, 1'b0, 16'h003C, 1'b0, 1'b0));

    // Flush_all together with a fill while waiting on a miss
    applyStimulus(mkVec(8'h55, 8'd3, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0));
    @(posedge clk); #1;
    fill_valid = 1'b1; fill_vpn = 8'h55; fill_ppn = 16'h0555; fill_asid = 8'd3;
    fill_user = 1'b1; fill_global = 1'b0; flush_all = 1'b1;
    @(negedge clk);
    checkOutput("fill_ready under flush", {31'd0, fill_ready}, 32'd0);
    @(posedge clk); #1;
    fill_valid = 1'b0; flush_all = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("req_ready after miss flush", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    applyStimulus(mkVec(8'h55, 8'd3, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0));
    escapeMiss();

    // Reset pulse while replaying
    applyStimulus(mkVec(8'h66, 8'd3, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0));
    @(posedge clk); #1;
    doFill(8'h66, 16'h0666, 8'd3, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rsp_valid in reset", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rsp_valid after reset", {31'd0, rsp_valid}, 32'd0);
    checkOutput("req_ready after mid reset", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    applyStimulus(mkVec(8'h66, 8'd3, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0));
    escapeMiss();
    applyStimulus(mkVec(8'h30, 8'd7, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0));
    escapeMiss();

    repeat (5) @(negedge clk);
    checkOutput("expectation queue drained", expQ.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
